axi_audio_out_lite_slave: RTL and testbench
===========================================

Name: axi_audio_out_lite_slave

Overview:
- AXI4-Lite responder (slave) for the audio-out peripheral: four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Register contents are exported to the audio datapath, with a one-cycle write pulse per register.
- Sits between the interconnect/master and the audio core; it is the target that the S00_AXI master writes and reads back.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address bits decoded; bits [3:2] select the register.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response, always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg0_out..reg3_out  out  32 each  current register contents.
- reg_wr_pulse  out  4  bit i high for exactly one cycle after a committed write to register i.

Behaviour:
- Reset (ARESET=1 at a rising edge) clears all registers, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA and reg_wr_pulse to 0.
  - An outstanding transaction is dropped; no response is issued for it.
- Write channel: AW and W are independent and may arrive in either order or in the same cycle.
  - Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - AWREADY=1 in IDLE and HAVE_W; WREADY=1 in IDLE and HAVE_AW. Both are 0 in RESP.
  - Handshake = VALID & READY at an edge. The address is latched on the AW handshake, data and strobes on the W handshake.
  - IDLE + both handshakes in the same cycle -> RESP. IDLE + AW only -> HAVE_AW. IDLE + W only -> HAVE_W.
  - HAVE_AW + W handshake -> RESP. HAVE_W + AW handshake -> RESP.
  - On entry to RESP (same edge): the register selected by addr[3:2] updates byte lane k only where WSTRB[k]=1; BVALID=1; BRESP=00.
  - The reg_wr_pulse bit is asserted the cycle after that edge, for one cycle, even when WSTRB=0.
  - RESP holds BVALID until BVALID&BREADY, then -> IDLE.
  - One outstanding write at a time.
  - Write latency: BVALID rises 1 cycle after the later of the two handshakes.
- Read channel: two states, IDLE and RDATA.
  - ARREADY=1 only in IDLE.
  - On the AR handshake: RDATA is loaded with the register selected by ARADDR[3:2], RVALID=1, RRESP=00, -> RDATA.
  - RDATA and RVALID hold stable until RVALID&RREADY, then -> IDLE.
  - Read latency: 1 cycle.
- Address decode: ADDR[1:0] ignored (unaligned addresses round down); bits above [3:2] alias.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- BREADY/RREADY held low indefinitely: the corresponding channel stalls; the other channel is unaffected.
- Read and write channels operate fully concurrently.

Decomposition:
- Package axi_audio_out_pkg:
  - RESP_OKAY = 2'b00.
  - Register index constants REG_CTRL=0, REG_LEFT=1, REG_RIGHT=2, REG_AUX=3.
  - Write FSM state enum.
- Sub-module axi_lite_regbank: the 4x32 storage with byte-strobe write port, one combinational read port and the pulse generation. The top keeps both channel FSMs.

Test Plan:
- Concurrent AW+W to 0x0 with 0x0101FFFF, WSTRB=F, then read 0x0 -> BRESP=00; RDATA=0x0101FFFF, RRESP=00; reg_wr_pulse=0001 for one cycle.
- Sequential write/read of 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x4, 0x8, 0xC -> each read matches its write; reg0_out is still 0x0101FFFF.
- W arrives 3 cycles before AW (addr 0x4, data 0x12345678) -> WREADY drops after the W handshake; BVALID asserts 1 cycle after the AW handshake; read returns 0x12345678.
- Write 0xFFFFFFFF to 0x8, then 0x000000AA with WSTRB=0001 -> read returns 0xFFFFFFAA.
- BREADY held low for 10 cycles while a read of 0xC is issued -> the read completes normally; AWREADY/WREADY stay 0 until B completes.
- Assert ARESET during the RESP state -> BVALID=0 the next cycle; all registers read back 0x00000000.

Source files
------------

// File: rtl/axi_audio_out_pkg.sv
// ============================================================================
// Module   : axi_audio_out_pkg
// Brief    : Shared constants, write FSM encoding and strobe helper for the
//            audio-out AXI4-Lite register slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_audio_out_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         NUM_REGS  = 4;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LEFT  = 2'd1;
    localparam logic [1:0] REG_RIGHT = 2'd2;
    localparam logic [1:0] REG_AUX   = 2'd3;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    // Expands a 4-bit byte-lane strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_audio_out_lite_slave_if.sv
// ============================================================================
// Module   : axi_audio_out_lite_slave_if
// Brief    : AXI4-Lite bus bundle between interconnect master and the slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi_audio_out_lite_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                        awprot;
    logic                              awvalid;
    logic                              awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                        arprot;
    logic                              arvalid;
    logic                              arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                        rresp;
    logic                              rvalid;
    logic                              rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_lite_regbank.sv
// ============================================================================
// Module   : axi_lite_regbank
// Brief    : 4x32 register storage with byte-strobe write port, combinational
//            read port and one-cycle per-register write pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_lite_regbank
    import axi_audio_out_pkg::*;
(
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      we,
    input  wire logic [1:0]                waddr,
    input  wire logic [31:0]               wdata,
    input  wire logic [3:0]                wstrb,
    input  wire logic [1:0]                raddr,
    output logic      [31:0]               rdata,
    output logic      [NUM_REGS-1:0][31:0] regs,
    output logic      [NUM_REGS-1:0]       pulse
);

    logic [NUM_REGS-1:0][31:0] r_regs;
    logic [NUM_REGS-1:0]       r_pulse;
    logic [31:0]               w_mask;

    assign w_mask = strb_to_mask(wstrb);

    // The pulse fires on every committed write, even an all-zero strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            if (we) begin
                r_regs[waddr]  <= (r_regs[waddr] & ~w_mask) | (wdata & w_mask);
                r_pulse[waddr] <= 1'b1;
            end
        end
    end

    assign rdata = r_regs[raddr];
    assign regs  = r_regs;
    assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/axi_audio_out_lite_slave.sv
// ============================================================================
// Module   : axi_audio_out_lite_slave
// Brief    : AXI4-Lite slave exposing four audio-out control registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_audio_out_lite_slave
    import axi_audio_out_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
)(
    input  wire logic                          ACLK,
    input  wire logic                          ARESET,
    axi_audio_out_lite_slave_if.slave          s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg3_out,
    output logic [NUM_REGS-1:0]                reg_wr_pulse
);

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    wr_state_e                         r_wr_state, w_wr_next;
    logic                              r_awready, r_wready;
    logic [1:0]                        r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [3:0]                        r_wstrb;
    logic                              w_aw_hs, w_w_hs, w_commit;
    logic [1:0]                        w_commit_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_commit_data;
    logic [3:0]                        w_commit_strb;

    logic [0:0]                        r_rd_state;
    logic                              r_arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_rdata;
    logic                              w_ar_hs;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_rd_word;
    logic [NUM_REGS-1:0][31:0]         w_regs;
    logic                              w_unused_ok;

    assign w_aw_hs = s_axi.awvalid & r_awready;
    assign w_w_hs  = s_axi.wvalid  & r_wready;
    assign w_ar_hs = s_axi.arvalid & r_arready;

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wr_next = WR_RESP;
                else if (w_aw_hs)      w_wr_next = WR_HAVE_AW;
                else if (w_w_hs)       w_wr_next = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_w_hs)        w_wr_next = WR_RESP;
            WR_HAVE_W:  if (w_aw_hs)       w_wr_next = WR_RESP;
            WR_RESP:    if (s_axi.bready)  w_wr_next = WR_IDLE;
            default:                       w_wr_next = WR_IDLE;
        endcase
    end

    // The commit edge uses whichever half arrives now straight off the bus.
    assign w_commit      = (w_wr_next == WR_RESP) && (r_wr_state != WR_RESP);
    assign w_commit_idx  = w_aw_hs ? s_axi.awaddr[3:2] : r_aw_idx;
    assign w_commit_data = w_w_hs  ? s_axi.wdata       : r_wdata;
    assign w_commit_strb = w_w_hs  ? s_axi.wstrb       : r_wstrb;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == WR_IDLE) || (w_wr_next == WR_HAVE_W);
            r_wready   <= (w_wr_next == WR_IDLE) || (w_wr_next == WR_HAVE_AW);
            if (w_aw_hs) r_aw_idx <= s_axi.awaddr[3:2];
            if (w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
        end
    end

    // Register file updates on the same edge a read samples it, so a
    // colliding read returns the pre-write value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rdata    <= w_rd_word;
                        r_rd_state <= RD_DATA;
                        r_arready  <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (s_axi.rready) begin
                        r_rd_state <= RD_IDLE;
                        r_arready  <= 1'b1;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    axi_lite_regbank u_regbank (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (w_commit),
        .waddr (w_commit_idx),
        .wdata (w_commit_data),
        .wstrb (w_commit_strb),
        .raddr (s_axi.araddr[3:2]),
        .rdata (w_rd_word),
        .regs  (w_regs),
        .pulse (reg_wr_pulse)
    );

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = (r_wr_state == WR_RESP);
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = (r_rd_state == RD_DATA);
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = RESP_OKAY;

    assign reg0_out = w_regs[REG_CTRL];
    assign reg1_out = w_regs[REG_LEFT];
    assign reg2_out = w_regs[REG_RIGHT];
    assign reg3_out = w_regs[REG_AUX];

    assign w_unused_ok = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

endmodule

`default_nettype wire

// File: tb/tb_axi_audio_out_lite_slave.sv
// ============================================================================
// Module   : tb_axi_audio_out_lite_slave
// Brief    : Directed self-checking bench for the audio-out AXI4-Lite slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_audio_out_lite_slave;

    logic        clk;
    logic        rst;
    logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [3:0]  reg_wr_pulse;
    int          n_checks;
    int          n_pass;
    int          n_fail;

    axi_audio_out_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

    axi_audio_out_lite_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .s_axi        (bus),
        .reg0_out     (reg0_out),
        .reg1_out     (reg1_out),
        .reg2_out     (reg2_out),
        .reg3_out     (reg3_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] exp_pulse, input int stall);
        logic aw_done, w_done, aw_now, w_now;
        int   cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = (stall == 0);
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_now = bus.awvalid && bus.awready;
            w_now  = bus.wvalid && bus.wready;
            @(posedge clk); #1; cyc++;
            if (aw_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check({tag, ":handshakes"}, 32'({aw_done, w_done}), 32'h3);
        check({tag, ":bvalid"},     32'(bus.bvalid),        32'h1);
        check({tag, ":bresp"},      32'(bus.bresp),         32'h0);
        check({tag, ":pulse"},      32'(reg_wr_pulse),      32'(exp_pulse));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ":bvalid_hold"},  32'(bus.bvalid),  32'h1);
            check({tag, ":awready_low"},  32'(bus.awready), 32'h0);
            check({tag, ":wready_low"},   32'(bus.wready),  32'h0);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        check({tag, ":bvalid_clear"}, 32'(bus.bvalid),   32'h0);
        check({tag, ":pulse_clear"},  32'(reg_wr_pulse), 32'h0);
    endtask

    task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic done, ar_now;
        int   cyc;
        done = 1'b0; cyc = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!done && cyc < 20) begin
            ar_now = bus.arvalid && bus.arready;
            @(posedge clk); #1; cyc++;
            if (ar_now) begin done = 1'b1; bus.arvalid = 1'b0; end
        end
        bus.arvalid = 1'b0;
        check({tag, ":handshake"}, 32'(done),       32'h1);
        check({tag, ":rvalid"},    32'(bus.rvalid), 32'h1);
        check({tag, ":rresp"},     32'(bus.rresp),  32'h0);
        check({tag, ":rdata"},     bus.rdata,       exp);
        @(posedge clk); #1;
        check({tag, ":rvalid_clear"}, 32'(bus.rvalid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset:awready", 32'(bus.awready),  32'h0);
        check("reset:wready",  32'(bus.wready),   32'h0);
        check("reset:bvalid",  32'(bus.bvalid),   32'h0);
        check("reset:arready", 32'(bus.arready),  32'h0);
        check("reset:rvalid",  32'(bus.rvalid),   32'h0);
        check("reset:rdata",   bus.rdata,         32'h0);
        check("reset:pulse",   32'(reg_wr_pulse), 32'h0);
        check("reset:reg0",    reg0_out,          32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle:awready", 32'(bus.awready), 32'h1);
        check("idle:wready",  32'(bus.wready),  32'h1);
        check("idle:arready", 32'(bus.arready), 32'h1);

        // Write and read of register 0 committing on the same edge.
        fork
            axi_write("coll_wr", 4'h0, 32'hCAFEF00D, 4'hF, 4'b0001, 0);
            axi_read ("coll_rd", 4'h0, 32'h0000_0000);
        join
        axi_read("coll_after", 4'h0, 32'hCAFEF00D);

        axi_write("wr0", 4'h0, 32'h0101FFFF, 4'hF, 4'b0001, 0);
        axi_read ("rd0", 4'h0, 32'h0101FFFF);
        axi_write("wr1", 4'h4, 32'hABCD0001, 4'hF, 4'b0010, 0);
        axi_read ("rd1", 4'h4, 32'hABCD0001);
        axi_write("wr2", 4'h8, 32'hDEAD0011, 4'hF, 4'b0100, 0);
        axi_read ("rd2", 4'h8, 32'hDEAD0011);
        axi_write("wr3", 4'hC, 32'hBEEF0011, 4'hF, 4'b1000, 0);
        axi_read ("rd3", 4'hC, 32'hBEEF0011);
        check("reg0_kept", reg0_out, 32'h0101FFFF);
        check("reg3_out",  reg3_out, 32'hBEEF0011);

        // W arrives three cycles ahead of AW.
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        check("wfirst:wready_drop", 32'(bus.wready),  32'h0);
        check("wfirst:awready",     32'(bus.awready), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("wfirst:no_bvalid", 32'(bus.bvalid), 32'h0);
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        check("wfirst:bvalid", 32'(bus.bvalid),   32'h1);
        check("wfirst:pulse",  32'(reg_wr_pulse), 32'h2);
        @(posedge clk); #1;
        check("wfirst:bvalid_clear", 32'(bus.bvalid), 32'h0);
        axi_read("wfirst_rd", 4'h4, 32'h12345678);

        // Byte strobes, empty strobe and unaligned read address.
        axi_write("full8",  4'h8, 32'hFFFFFFFF, 4'hF,    4'b0100, 0);
        axi_write("byte8",  4'h8, 32'h000000AA, 4'b0001, 4'b0100, 0);
        axi_read ("byte8_rd", 4'h8, 32'hFFFFFFAA);
        axi_write("nostrb", 4'hC, 32'h00000000, 4'h0,    4'b1000, 0);
        axi_read ("nostrb_rd", 4'hC, 32'hBEEF0011);
        axi_read ("unalign_rd", 4'hB, 32'hFFFFFFAA);

        // Write response stalled while a read proceeds.
        fork
            axi_write("stall_wr", 4'h4, 32'h55AA55AA, 4'hF, 4'b0010, 10);
            begin
                repeat (2) @(posedge clk);
                #1;
                axi_read("stall_rd", 4'hC, 32'hBEEF0011);
            end
        join
        axi_read("stall_after", 4'h4, 32'h55AA55AA);

        // Reset while a write response is pending.
        bus.awaddr = 4'h8; bus.wdata = 32'h00000001; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("rstresp:bvalid_before", 32'(bus.bvalid), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstresp:bvalid", 32'(bus.bvalid),   32'h0);
        check("rstresp:pulse",  32'(reg_wr_pulse), 32'h0);
        rst = 1'b0; bus.bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rstresp:no_resp", 32'(bus.bvalid), 32'h0);
        check("rstresp:reg1",    reg1_out,        32'h0);
        axi_read("rst_rd0", 4'h0, 32'h0);
        axi_read("rst_rd1", 4'h4, 32'h0);
        axi_read("rst_rd2", 4'h8, 32'h0);
        axi_read("rst_rd3", 4'hC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
